// File: rtl/bookkeeping_directory_mc_if.sv
// Request/response handshake bundle for the multi-core bookkeeping directory.
// master = core-side requester/consumer, slave = directory.
interface bookkeeping_directory_mc_if #(
    parameter int NCORES = 2,
    parameter int ADDR_W = 32
);
    localparam int CW     = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int REQ_W  = 2 + CW + ADDR_W;
    localparam int RESP_W = 2 + NCORES + 1 + CW + ADDR_W;

    logic              put_valid;
    logic [REQ_W-1:0]  put_request;
    logic              put_ready;
    logic              get_valid;
    logic              get_ready;
    logic [RESP_W-1:0] get_response;

    modport master (
        output put_valid, put_request, get_valid,
        input  put_ready, get_ready, get_response
    );

    modport slave (
        input  put_valid, put_request, get_valid,
        output put_ready, get_ready, get_response
    );
endinterface

// File: rtl/bookkeeping_directory_mc.sv
// Multi-core sharer/owner directory: direct-mapped tagged table, latency-1 response FIFO.
// Optional hit/miss/conflict counters on stats_o when BOOKKEEPING_STATS_EN is defined.
module bookkeeping_directory_mc #(
    parameter int NCORES     = 2,
    parameter int ADDR_W     = 32,
    parameter int LINE_OFF   = 6,
    parameter int INDEX_W    = 6,
    parameter int RESP_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    bookkeeping_directory_mc_if.slave bus
`ifdef BOOKKEEPING_STATS_EN
    ,
    output logic [95:0] stats_o
`endif
);
    localparam int CW      = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int REQ_W   = 2 + CW + ADDR_W;
    localparam int RESP_W  = 2 + NCORES + 1 + CW + ADDR_W;
    localparam int TAG_W   = ADDR_W - LINE_OFF - INDEX_W;
    localparam int ENTRIES = 1 << INDEX_W;
    localparam int PW      = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W   = $clog2(RESP_DEPTH + 1);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_EVICT = 2'b10;
    localparam logic [1:0] OP_QUERY = 2'b11;

    localparam logic [1:0] ST_HIT      = 2'd0;
    localparam logic [1:0] ST_MISS     = 2'd1;
    localparam logic [1:0] ST_CONFLICT = 2'd2;

    // Directory table
    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] owner_v_q;
    logic [TAG_W-1:0]   tag_q     [ENTRIES];
    logic [NCORES-1:0]  sharers_q [ENTRIES];
    logic [CW-1:0]      owner_q   [ENTRIES];

    // Response FIFO
    logic [RESP_W-1:0]  resp_mem_q [RESP_DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [1:0]         req_op;
    logic [CW-1:0]      req_core;
    logic [INDEX_W-1:0] req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               core_ok;
    logic [1:0]         eff_op;
    logic [NCORES-1:0]  core_oh;

    logic               e_valid, e_owner_v;
    logic [TAG_W-1:0]   e_tag;
    logic [NCORES-1:0]  e_sharers;
    logic [CW-1:0]      e_owner;
    logic               hit, conflict;
    logic [1:0]         status;

    logic               n_valid, n_owner_v, tbl_we;
    logic [TAG_W-1:0]   n_tag;
    logic [NCORES-1:0]  n_sharers;
    logic [CW-1:0]      n_owner;

    logic [RESP_W-1:0]  resp_word;
    logic               accept, pop;

    assign req_op   = bus.put_request[REQ_W-1 -: 2];
    assign req_core = bus.put_request[ADDR_W +: CW];
    assign req_idx  = bus.put_request[LINE_OFF +: INDEX_W];
    assign req_tag  = bus.put_request[ADDR_W-1 -: TAG_W];

    // Out-of-range core ids degrade to a read-only lookup.
    assign core_ok = ({1'b0, req_core} < (CW+1)'(NCORES));
    assign eff_op  = core_ok ? req_op : OP_QUERY;
    assign core_oh = NCORES'(1) << req_core;

    assign e_valid   = valid_q[req_idx];
    assign e_owner_v = owner_v_q[req_idx];
    assign e_tag     = tag_q[req_idx];
    assign e_sharers = sharers_q[req_idx];
    assign e_owner   = owner_q[req_idx];

    assign hit      = e_valid && (e_tag == req_tag);
    assign conflict = e_valid && (e_tag != req_tag);
    assign status   = !e_valid ? ST_MISS : (hit ? ST_HIT : ST_CONFLICT);

    always_comb begin
        n_valid   = e_valid;
        n_tag     = e_tag;
        n_sharers = e_sharers;
        n_owner_v = e_owner_v;
        n_owner   = e_owner;
        tbl_we    = 1'b0;
        case (eff_op)
            OP_READ: begin
                tbl_we = 1'b1;
                if (hit) begin
                    n_sharers = e_sharers | core_oh;
                    if (e_owner != req_core) n_owner_v = 1'b0;
                end else begin
                    n_valid   = 1'b1;
                    n_tag     = req_tag;
                    n_sharers = core_oh;
                    n_owner_v = 1'b0;
                    n_owner   = '0;
                end
            end
            OP_WRITE: begin
                tbl_we    = 1'b1;
                n_valid   = 1'b1;
                n_tag     = req_tag;
                n_sharers = core_oh;
                n_owner_v = 1'b1;
                n_owner   = req_core;
            end
            OP_EVICT: begin
                tbl_we    = hit;
                n_sharers = e_sharers & ~core_oh;
                if (e_owner == req_core) n_owner_v = 1'b0;
                if (n_sharers == '0) n_valid = 1'b0;
            end
            default: tbl_we = 1'b0;
        endcase
    end

    // Previous contents are reported only for a valid entry; victim only on conflict.
    assign resp_word = {status,
                        e_valid ? e_sharers : {NCORES{1'b0}},
                        e_valid & e_owner_v,
                        e_valid ? e_owner : {CW{1'b0}},
                        conflict ? {e_tag, req_idx, {LINE_OFF{1'b0}}} : {ADDR_W{1'b0}}};

    assign bus.put_ready    = (count_q < CNT_W'(RESP_DEPTH));
    assign bus.get_ready    = (count_q != '0);
    assign bus.get_response = bus.get_ready ? resp_mem_q[rd_ptr_q] : '0;
    assign accept = bus.put_valid && bus.put_ready;
    assign pop    = bus.get_valid && bus.get_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            owner_v_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]     <= '0;
                sharers_q[i] <= '0;
                owner_q[i]   <= '0;
            end
        end else if (accept && tbl_we) begin
            valid_q[req_idx]   <= n_valid;
            owner_v_q[req_idx] <= n_owner_v;
            tag_q[req_idx]     <= n_tag;
            sharers_q[req_idx] <= n_sharers;
            owner_q[req_idx]   <= n_owner;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (accept) wr_ptr_d = (wr_ptr_q == PW'(RESP_DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)    rd_ptr_d = (rd_ptr_q == PW'(RESP_DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
        if (accept && !pop)      count_d = count_q + 1'b1;
        else if (!accept && pop) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them.
    always_ff @(posedge clk) begin
        if (accept) resp_mem_q[wr_ptr_q] <= resp_word;
    end

`ifdef BOOKKEEPING_STATS_EN
    logic [31:0] hits_q, misses_q, conflicts_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hits_q      <= '0;
            misses_q    <= '0;
            conflicts_q <= '0;
        end else if (accept) begin
            if (status == ST_HIT && hits_q != '1)           hits_q      <= hits_q + 1'b1;
            if (status == ST_MISS && misses_q != '1)        misses_q    <= misses_q + 1'b1;
            if (status == ST_CONFLICT && conflicts_q != '1) conflicts_q <= conflicts_q + 1'b1;
        end
    end

    assign stats_o = {hits_q, misses_q, conflicts_q};
`endif
endmodule

// File: tb/tb_bookkeeping_directory_mc.sv
// Directed bench for bookkeeping_directory_mc (NCORES=2, default geometry).
// Stats checks are compiled in when BOOKKEEPING_STATS_EN is defined.
module tb_bookkeeping_directory_mc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bookkeeping_directory_mc_if #(.NCORES(2), .ADDR_W(32)) bus ();

`ifdef BOOKKEEPING_STATS_EN
    logic [95:0] stats;
`endif

    bookkeeping_directory_mc #(
        .NCORES(2), .ADDR_W(32), .LINE_OFF(6), .INDEX_W(6), .RESP_DEPTH(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef BOOKKEEPING_STATS_EN
        ,
        .stats_o (stats)
`endif
    );

    localparam logic [1:0] RD = 2'b00, WR = 2'b01, EV = 2'b10, QY = 2'b11;
    localparam logic [1:0] HIT = 2'd0, MISS = 2'd1, CONF = 2'd2;

    function automatic logic [37:0] mk(logic [1:0] st, logic [1:0] sh, logic ov,
                                       logic ow, logic [31:0] va);
        return {st, sh, ov, ow, va};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic req(logic [1:0] op, logic c, logic [31:0] a);
        bus.put_request = {op, c, a};
        bus.put_valid   = 1'b1;
        @(posedge clk); #1;
        bus.put_valid   = 1'b0;
    endtask

    task automatic pop_check(string tag, logic [37:0] exp);
        chk({tag, "_rdy"}, 64'(bus.get_ready), 64'd1);
        chk(tag, 64'(bus.get_response), 64'(exp));
        bus.get_valid = 1'b1;
        @(posedge clk); #1;
        bus.get_valid = 1'b0;
    endtask

    logic [34:0] burst [5];
    logic [37:0] burst_exp [5];

    initial begin
        bus.put_valid   = 1'b0;
        bus.put_request = '0;
        bus.get_valid   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_get_ready", 64'(bus.get_ready), 64'd0);
        chk("rst_put_ready", 64'(bus.put_ready), 64'd1);
        chk("rst_get_resp", 64'(bus.get_response), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Sharing and ownership on one line
        req(RD, 1'b0, 32'h1000);
        pop_check("rd_c0_miss", mk(MISS, 2'b00, 1'b0, 1'b0, 32'h0));
        chk("empty_after_pop", 64'(bus.get_ready), 64'd0);
        req(RD, 1'b1, 32'h1000);
        pop_check("rd_c1_hit", mk(HIT, 2'b01, 1'b0, 1'b0, 32'h0));
        req(WR, 1'b1, 32'h1000);
        pop_check("wr_c1_hit", mk(HIT, 2'b11, 1'b0, 1'b0, 32'h0));
        req(QY, 1'b0, 32'h1000);
        pop_check("qy_owner", mk(HIT, 2'b10, 1'b1, 1'b1, 32'h0));

        // Index collision replaces the line
        req(RD, 1'b0, 32'h2000);
        pop_check("rd_conflict", mk(CONF, 2'b10, 1'b1, 1'b1, 32'h1000));
        req(QY, 1'b0, 32'h2000);
        pop_check("qy_2000", mk(HIT, 2'b01, 1'b0, 1'b0, 32'h0));

        // Evictions
        req(EV, 1'b0, 32'h2000);
        pop_check("ev_hit", mk(HIT, 2'b01, 1'b0, 1'b0, 32'h0));
        req(QY, 1'b0, 32'h2000);
        pop_check("qy_invalid", mk(MISS, 2'b00, 1'b0, 1'b0, 32'h0));
        req(EV, 1'b1, 32'h3000);
        pop_check("ev_miss", mk(MISS, 2'b00, 1'b0, 1'b0, 32'h0));
        req(QY, 1'b1, 32'h3000);
        pop_check("qy_after_ev_miss", mk(MISS, 2'b00, 1'b0, 1'b0, 32'h0));

        // Back-to-back requests fill the FIFO; fifth waits for a pop
        burst[0] = {WR, 1'b0, 32'h1040}; burst_exp[0] = mk(MISS, 2'b00, 1'b0, 1'b0, 32'h0);
        burst[1] = {RD, 1'b1, 32'h1040}; burst_exp[1] = mk(HIT,  2'b01, 1'b1, 1'b0, 32'h0);
        burst[2] = {QY, 1'b0, 32'h1040}; burst_exp[2] = mk(HIT,  2'b11, 1'b0, 1'b0, 32'h0);
        burst[3] = {RD, 1'b0, 32'h5040}; burst_exp[3] = mk(CONF, 2'b11, 1'b0, 1'b0, 32'h1040);
        burst[4] = {QY, 1'b1, 32'h5040}; burst_exp[4] = mk(HIT,  2'b01, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            bus.put_request = burst[i];
            bus.put_valid   = 1'b1;
            @(posedge clk); #1;
        end
        chk("full_put_ready", 64'(bus.put_ready), 64'd0);
        bus.put_request = burst[4];
        @(posedge clk); #1;
        chk("held_put_ready", 64'(bus.put_ready), 64'd0);
        chk("held_head", 64'(bus.get_response), 64'(burst_exp[0]));
        bus.get_valid = 1'b1;
        @(posedge clk); #1;
        bus.get_valid = 1'b0;
        chk("after_pop_put_ready", 64'(bus.put_ready), 64'd1);
        @(posedge clk); #1;
        bus.put_valid = 1'b0;
        chk("refull_put_ready", 64'(bus.put_ready), 64'd0);
        for (int i = 1; i < 5; i++) pop_check($sformatf("burst%0d", i), burst_exp[i]);
        chk("burst_drained", 64'(bus.get_ready), 64'd0);

        // Asynchronous reset with responses queued
        req(RD, 1'b0, 32'h2000);
        req(QY, 1'b0, 32'h2000);
        chk("pre_rst_get_ready", 64'(bus.get_ready), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_get_ready", 64'(bus.get_ready), 64'd0);
        chk("mid_rst_get_resp", 64'(bus.get_response), 64'd0);
        chk("mid_rst_put_ready", 64'(bus.put_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
`ifdef BOOKKEEPING_STATS_EN
        chk("stats_cleared", 64'(stats), 64'd0);
`endif
        req(QY, 1'b0, 32'h2000);
        pop_check("post_rst_miss", mk(MISS, 2'b00, 1'b0, 1'b0, 32'h0));
`ifdef BOOKKEEPING_STATS_EN
        chk("stats_hits", 64'(stats[95:64]), 64'd0);
        chk("stats_misses", 64'(stats[63:32]), 64'd1);
        chk("stats_conflicts", 64'(stats[31:0]), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
